// File: rtl/soc_mgmt_pkg.sv
// ============================================================================
// soc_mgmt_pkg : shared types and constants for the KSE JTAG TDR controller
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package soc_mgmt_pkg;

  localparam int KSE3_JTAG_HAW          = 32;
  localparam int SOC_MGMT_HDW           = 32;
  localparam int KSE_JTAG_TDR_CMD_DEPTH = 4;

  typedef enum logic [2:0] {
    KSE_JTAG_OP_NOP          = 3'd0,
    KSE_JTAG_OP_READ         = 3'd1,
    KSE_JTAG_OP_WRITE        = 3'd2,
    KSE_JTAG_OP_ENTER_ACCESS = 3'd3,
    KSE_JTAG_OP_INIT_ADAC    = 3'd4,
    KSE_JTAG_OP_DBG_SET      = 3'd5,
    KSE_JTAG_OP_DBG_CLR      = 3'd6,
    KSE_JTAG_OP_FLUSH        = 3'd7
  } kse_jtag_op_e;

  typedef struct packed {
    kse_jtag_op_e               op;
    logic [SOC_MGMT_HDW-1:0]    wdata;
    logic [KSE3_JTAG_HAW-1:0]   addr;
  } kse_jtag_cmd_t;

  // Capture-word bit offsets, relative to the end of last_rdata
  localparam int CAP_KSE_ERR  = 0;
  localparam int CAP_AHB_ERR  = 1;
  localparam int CAP_CMD_IGN  = 2;
  localparam int CAP_BUSY     = 3;
  localparam int CAP_FULL     = 4;
  localparam int CAP_OVERFLOW = 5;
  localparam int CAP_TIMEOUT  = 6;
  localparam int CAP_TXN_ID   = 7;
  localparam int CAP_LEVEL    = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } kse_jtag_state_e;

  function automatic logic kse_jtag_op_is_queued(input kse_jtag_op_e op);
    return (op == KSE_JTAG_OP_READ) || (op == KSE_JTAG_OP_WRITE) ||
           (op == KSE_JTAG_OP_ENTER_ACCESS) || (op == KSE_JTAG_OP_INIT_ADAC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/kse_jtag_cmd_fifo.sv
// ============================================================================
// kse_jtag_cmd_fifo : register FIFO with push/pop/flush, full/empty/level
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module kse_jtag_cmd_fifo
  import soc_mgmt_pkg::*;
#(
  parameter int  DEPTH = KSE_JTAG_TDR_CMD_DEPTH,
  parameter type T     = kse_jtag_cmd_t
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output T                         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign o_full  = (cnt_q == (AW+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_level = cnt_q;
  assign o_data  = mem_q[rd_q];
  // A full FIFO drops the push even when a pop frees a slot this cycle
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/kse_jtag_tdr_ctrl.sv
// ============================================================================
// kse_jtag_tdr_ctrl : JTAG TDR, command queue and KSE3 issue/response FSM
// Optional response watchdog: `define KSE_JTAG_TDR_TIMEOUT_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module kse_jtag_tdr_ctrl
  import soc_mgmt_pkg::*;
#(
  parameter int HAW       = KSE3_JTAG_HAW,
  parameter int HDW       = SOC_MGMT_HDW,
  parameter int CMD_DEPTH = KSE_JTAG_TDR_CMD_DEPTH,
  parameter int TIMEOUT_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_tdr_sel,
  input  logic            i_capture_dr,
  input  logic            i_shift_dr,
  input  logic            i_update_dr,
  input  logic            i_tdi,
  output logic            o_tdo,
  output logic [HAW-1:0]  o_ahb_haddr,
  output logic [HDW-1:0]  o_ahb_hwdata,
  output logic            o_ahb_hwrite,
  output logic            o_ahb_valid,
  output logic            o_enter_jtag_access_mode,
  output logic            o_init_kse3_adac_itf,
  output logic            o_jtag_dbg,
  output logic            o_transaction_id,
  input  logic [HDW-1:0]  i_ahb_hrdata,
  input  logic            i_jtag_ready,
  input  logic            i_jtag_kse_error,
  input  logic            i_jtag_ahb_error,
  input  logic            i_jtag_cmd_ignored
);

  localparam int TDR_W = HAW + HDW + 3;
  localparam int LVL_W = $clog2(CMD_DEPTH) + 1;

  typedef struct packed {
    kse_jtag_op_e   op;
    logic [HDW-1:0] wdata;
    logic [HAW-1:0] addr;
  } cmd_t;

  if ((TDR_W < HDW + 8 + LVL_W) || (CMD_DEPTH < 2) || (TIMEOUT_W < 1) ||
      ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_param_chk
    $error("kse_jtag_tdr_ctrl: illegal parameter combination");
  end

  logic [TDR_W-1:0] sr_q, sr_d, cap_word;
  logic             upd_vld_q;
  cmd_t             upd_cmd_q;
  kse_jtag_state_e  state_q, state_d;
  logic             valid_q, valid_d, hwrite_q, hwrite_d;
  logic             enter_q, enter_d, init_q, init_d;
  logic             dbg_q, dbg_d, txn_q, txn_d;
  logic [HAW-1:0]   haddr_q, haddr_d;
  logic [HDW-1:0]   hwdata_q, hwdata_d, rdata_q, rdata_d;
  logic             kse_err_q, kse_err_d, ahb_err_q, ahb_err_d, ign_q, ign_d;
  logic             ovf_q, ovf_d, tmo_q, tmo_d;

  logic             do_cap, do_shift, do_upd;
  logic             push, pop, flush, fifo_full, fifo_empty, tmo_expire;
  cmd_t             head;
  logic [LVL_W-1:0] fifo_level;

  assign do_cap   = i_tdr_sel & i_capture_dr;
  assign do_shift = i_tdr_sel & i_shift_dr & ~i_capture_dr;
  assign do_upd   = i_tdr_sel & i_update_dr & ~i_capture_dr & ~i_shift_dr;
  assign push     = upd_vld_q & kse_jtag_op_is_queued(upd_cmd_q.op);
  assign flush    = upd_vld_q & (upd_cmd_q.op == KSE_JTAG_OP_FLUSH);

  kse_jtag_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (upd_cmd_q),
    .i_pop   (pop),
    .i_flush (flush),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

`ifdef KSE_JTAG_TDR_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || (state_q == ST_IDLE)) tmo_cnt_q <= '0;
    else                               tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
  end

  assign tmo_expire = &(tmo_cnt_q + TIMEOUT_W'(1));
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    cap_word = '0;
    cap_word[HDW-1:0]                = rdata_q;
    cap_word[HDW + CAP_KSE_ERR]      = kse_err_q;
    cap_word[HDW + CAP_AHB_ERR]      = ahb_err_q;
    cap_word[HDW + CAP_CMD_IGN]      = ign_q;
    cap_word[HDW + CAP_BUSY]         = valid_q | ~fifo_empty;
    cap_word[HDW + CAP_FULL]         = fifo_full;
    cap_word[HDW + CAP_OVERFLOW]     = ovf_q;
    cap_word[HDW + CAP_TIMEOUT]      = tmo_q;
    cap_word[HDW + CAP_TXN_ID]       = txn_q;
    cap_word[HDW + CAP_LEVEL +: LVL_W] = fifo_level;
  end

  always_comb begin
    sr_d = sr_q;
    if (do_cap)        sr_d = cap_word;
    else if (do_shift) sr_d = {i_tdi, sr_q[TDR_W-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    haddr_d   = haddr_q;
    hwdata_d  = hwdata_q;
    hwrite_d  = hwrite_q;
    enter_d   = enter_q;
    init_d    = init_q;
    txn_d     = txn_q;
    rdata_d   = rdata_q;
    kse_err_d = kse_err_q;
    ahb_err_d = ahb_err_q;
    ign_d     = ign_q;
    dbg_d     = dbg_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          valid_d  = 1'b1;
          haddr_d  = head.addr;
          hwdata_d = head.wdata;
          hwrite_d = (head.op == KSE_JTAG_OP_WRITE);
          enter_d  = (head.op == KSE_JTAG_OP_ENTER_ACCESS);
          init_d   = (head.op == KSE_JTAG_OP_INIT_ADAC);
          txn_d    = ~txn_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response arriving on the expiry cycle takes precedence
        if (i_jtag_ready) begin
          valid_d   = 1'b0;
          enter_d   = 1'b0;
          init_d    = 1'b0;
          rdata_d   = i_ahb_hrdata;
          kse_err_d = i_jtag_kse_error;
          ahb_err_d = i_jtag_ahb_error;
          ign_d     = i_jtag_cmd_ignored;
          state_d   = ST_IDLE;
        end else if (tmo_expire) begin
          valid_d = 1'b0;
          enter_d = 1'b0;
          init_d  = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_cap) begin
      ovf_d = 1'b0;
      if (!(state_q == ST_WAIT && !i_jtag_ready && tmo_expire)) tmo_d = 1'b0;
    end
    if (upd_vld_q) begin
      case (upd_cmd_q.op)
        KSE_JTAG_OP_DBG_SET: dbg_d = 1'b1;
        KSE_JTAG_OP_DBG_CLR: dbg_d = 1'b0;
        KSE_JTAG_OP_FLUSH:   ovf_d = 1'b0;
        default:             ;
      endcase
    end
    if (push && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q      <= '0;
      upd_vld_q <= 1'b0;
      upd_cmd_q <= '0;
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      haddr_q   <= '0;
      hwdata_q  <= '0;
      hwrite_q  <= 1'b0;
      enter_q   <= 1'b0;
      init_q    <= 1'b0;
      txn_q     <= 1'b0;
      rdata_q   <= '0;
      kse_err_q <= 1'b0;
      ahb_err_q <= 1'b0;
      ign_q     <= 1'b0;
      dbg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      upd_vld_q <= do_upd;
      upd_cmd_q <= cmd_t'(sr_q);
      state_q   <= state_d;
      valid_q   <= valid_d;
      haddr_q   <= haddr_d;
      hwdata_q  <= hwdata_d;
      hwrite_q  <= hwrite_d;
      enter_q   <= enter_d;
      init_q    <= init_d;
      txn_q     <= txn_d;
      rdata_q   <= rdata_d;
      kse_err_q <= kse_err_d;
      ahb_err_q <= ahb_err_d;
      ign_q     <= ign_d;
      dbg_q     <= dbg_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
    end
  end

  assign o_tdo                    = sr_q[0];
  assign o_ahb_haddr              = haddr_q;
  assign o_ahb_hwdata             = hwdata_q;
  assign o_ahb_hwrite             = hwrite_q;
  assign o_ahb_valid              = valid_q;
  assign o_enter_jtag_access_mode = enter_q;
  assign o_init_kse3_adac_itf     = init_q;
  assign o_jtag_dbg               = dbg_q;
  assign o_transaction_id         = txn_q;

endmodule

`default_nettype wire

// File: tb/tb_kse_jtag_tdr_ctrl.sv
// ============================================================================
// tb_kse_jtag_tdr_ctrl : scoreboard bench for kse_jtag_tdr_ctrl
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_kse_jtag_tdr_ctrl;

  localparam int HAW   = 16;
  localparam int HDW   = 32;
  localparam int TDR_W = HAW + HDW + 3;
  localparam int B_KSE = HDW + 0;
  localparam int B_AHB = HDW + 1;
  localparam int B_IGN = HDW + 2;
  localparam int B_BSY = HDW + 3;
  localparam int B_FUL = HDW + 4;
  localparam int B_OVF = HDW + 5;
  localparam int B_TMO = HDW + 6;
  localparam int B_TXN = HDW + 7;
  localparam int B_LVL = HDW + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0, cap = 1'b0, shf = 1'b0, upd = 1'b0, tdi = 1'b0;
  logic tdo, hwrite, valid, enter, init_q, dbg, txn;
  logic [HAW-1:0] haddr;
  logic [HDW-1:0] hwdata;
  logic [HDW-1:0] hrdata = '0;
  logic rdy = 1'b0, kerr = 1'b0, aerr = 1'b0, ign = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kse_jtag_tdr_ctrl #(
    .HAW(HAW), .HDW(HDW), .CMD_DEPTH(4), .TIMEOUT_W(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_tdr_sel(sel), .i_capture_dr(cap),
    .i_shift_dr(shf), .i_update_dr(upd), .i_tdi(tdi), .o_tdo(tdo),
    .o_ahb_haddr(haddr), .o_ahb_hwdata(hwdata), .o_ahb_hwrite(hwrite),
    .o_ahb_valid(valid), .o_enter_jtag_access_mode(enter),
    .o_init_kse3_adac_itf(init_q), .o_jtag_dbg(dbg),
    .o_transaction_id(txn), .i_ahb_hrdata(hrdata), .i_jtag_ready(rdy),
    .i_jtag_kse_error(kerr), .i_jtag_ahb_error(aerr),
    .i_jtag_cmd_ignored(ign)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [HAW-1:0] addr;
    logic [HDW-1:0] data;
    logic           wr;
    logic           ent;
    logic           ini;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_valid = 1'b0;
  logic exp_txn    = 1'b0;

  // Scoreboard: each rising valid must match the oldest expected command
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      exp_txn    = 1'b0;
    end else begin
      if (valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          mon_e   = exp_q.pop_front();
          exp_txn = ~exp_txn;
          chk("issue_haddr", haddr, mon_e.addr);
          chk("issue_hwdata", hwdata, mon_e.data);
          chk("issue_hwrite", hwrite, mon_e.wr);
          chk("issue_enter", enter, mon_e.ent);
          chk("issue_init", init_q, mon_e.ini);
          chk("issue_txn", txn, exp_txn);
        end
      end
      prev_valid = valid;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_in(input logic [TDR_W-1:0] din, output logic [TDR_W-1:0] dout);
    sel = 1'b1;
    for (int k = 0; k < TDR_W; k++) begin
      dout[k] = tdo;
      tdi     = din[k];
      shf     = 1'b1;
      @(negedge clk);
    end
    shf = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic capture(output logic [TDR_W-1:0] cw);
    sel = 1'b1;
    cap = 1'b1;
    @(negedge clk);
    cap = 1'b0;
    shift_in('0, cw);
  endtask

  task automatic pulse_update();
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [HAW-1:0] a, input logic [HDW-1:0] d);
    logic [TDR_W-1:0] v;
    logic [TDR_W-1:0] unused_out;
    v = {op, d, a};
    shift_in(v, unused_out);
    pulse_update();
  endtask

  task automatic expect_cmd(input logic [2:0] op, input logic [HAW-1:0] a, input logic [HDW-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.wr   = (op == 3'd2);
    e.ent  = (op == 3'd3);
    e.ini  = (op == 3'd4);
    exp_q.push_back(e);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
    if (!valid) chk("valid_wait_expired", 0, 1);
  endtask

  task automatic respond(input logic [HDW-1:0] rd, input logic k, input logic a, input logic i);
    wait_valid();
    hrdata = rd;
    kerr   = k;
    aerr   = a;
    ign    = i;
    rdy    = 1'b1;
    tick();
    rdy    = 1'b0;
    kerr   = 1'b0;
    aerr   = 1'b0;
    ign    = 1'b0;
    chk("valid_drop_after_ready", valid, 0);
  endtask

  logic [TDR_W-1:0] cw;

  initial begin
    tick(3);
    chk("rst_valid", valid, 0);
    chk("rst_tdo", tdo, 0);
    chk("rst_dbg", dbg, 0);
    chk("rst_txn", txn, 0);
    rst = 1'b0;
    tick();

    // WRITE latency and issue
    expect_cmd(3'd2, 16'h1000, 32'hDEADBEEF);
    send_cmd(3'd2, 16'h1000, 32'hDEADBEEF);
    chk("lat_edge0_valid", valid, 0);
    tick();
    chk("lat_edge1_valid", valid, 0);
    tick();
    chk("lat_edge2_valid", valid, 1);
    chk("lat_txn", txn, 1);
    tick(3);
    chk("hold_haddr", haddr, 16'h1000);
    respond(32'h0, 1'b0, 1'b0, 1'b0);

    // READ response with AHB error
    expect_cmd(3'd1, 16'h0020, 32'h0);
    send_cmd(3'd1, 16'h0020, 32'h0);
    respond(32'hA5A5_0001, 1'b0, 1'b1, 1'b0);
    capture(cw);
    chk("rd_rdata", cw[HDW-1:0], 32'hA5A5_0001);
    chk("rd_kse_err", cw[B_KSE], 0);
    chk("rd_ahb_err", cw[B_AHB], 1);
    chk("rd_ign", cw[B_IGN], 0);
    chk("rd_busy", cw[B_BSY], 0);
    chk("rd_timeout", cw[B_TMO], 0);
    chk("rd_txn", cw[B_TXN], 0);

    // Overflow: one in flight, four queued, one dropped
    for (int k = 0; k < 6; k++) begin
      if (k < 5) expect_cmd(3'd2, 16'h0100 + 16'(k), 32'h1111_0000 + 32'(k));
      send_cmd(3'd2, 16'h0100 + 16'(k), 32'h1111_0000 + 32'(k));
    end
    tick(2);
    capture(cw);
    chk("ovf_overflow", cw[B_OVF], 1);
    chk("ovf_full", cw[B_FUL], 1);
    chk("ovf_level", cw[B_LVL +: 3], 4);
    chk("ovf_busy", cw[B_BSY], 1);
    capture(cw);
    chk("ovf_cleared", cw[B_OVF], 0);
    for (int k = 0; k < 5; k++) respond(32'h0000_1000 + 32'(k), 1'b0, 1'b0, 1'b1);
    capture(cw);
    chk("drain_rdata", cw[HDW-1:0], 32'h0000_1004);
    chk("drain_ign", cw[B_IGN], 1);
    chk("drain_txn", cw[B_TXN], 1);
    chk("drain_level", cw[B_LVL +: 3], 0);

    // Flush of queued entries; in-flight command completes
    expect_cmd(3'd3, 16'h0200, 32'h0000_0200);
    send_cmd(3'd3, 16'h0200, 32'h0000_0200);
    for (int k = 1; k < 4; k++) send_cmd(3'd4, 16'h0200 + 16'(k), 32'h0000_0200 + 32'(k));
    send_cmd(3'd7, 16'h0, 32'h0);
    respond(32'h55, 1'b1, 1'b0, 1'b0);
    tick(10);
    chk("flush_no_valid", valid, 0);
    capture(cw);
    chk("flush_level", cw[B_LVL +: 3], 0);
    chk("flush_busy", cw[B_BSY], 0);
    chk("flush_kse_err", cw[B_KSE], 1);
    chk("flush_txn", cw[B_TXN], 0);

    // DBG level, including an update seen while deselected
    shift_in({3'd5, 32'h0, 16'h0}, cw);
    sel = 1'b0;
    pulse_update();
    tick();
    chk("dbg_desel_ignored", dbg, 0);
    sel = 1'b1;
    pulse_update();
    tick();
    chk("dbg_set", dbg, 1);
    chk("dbg_no_valid", valid, 0);
    send_cmd(3'd6, 16'h0, 32'h0);
    tick();
    chk("dbg_clr", dbg, 0);

    // Reset while waiting for a response
    send_cmd(3'd5, 16'h0, 32'h0);
    expect_cmd(3'd2, 16'h0300, 32'hCAFE_0300);
    send_cmd(3'd2, 16'h0300, 32'hCAFE_0300);
    wait_valid();
    send_cmd(3'd2, 16'h0301, 32'hCAFE_0301);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_haddr", haddr, 0);
    chk("mid_rst_hwdata", hwdata, 0);
    chk("mid_rst_hwrite", hwrite, 0);
    chk("mid_rst_txn", txn, 0);
    chk("mid_rst_dbg", dbg, 0);
    exp_q.delete();
    rst    = 1'b0;
    hrdata = 32'hFFFF_FFFF;
    aerr   = 1'b1;
    rdy    = 1'b1;
    tick();
    rdy    = 1'b0;
    aerr   = 1'b0;
    tick(5);
    capture(cw);
    chk("stray_rdata", cw[HDW-1:0], 0);
    chk("stray_ahb_err", cw[B_AHB], 0);
    chk("stray_level", cw[B_LVL +: 3], 0);
    chk("stray_valid", valid, 0);

`ifdef KSE_JTAG_TDR_TIMEOUT_EN
    begin
      int hi = 0;
      expect_cmd(3'd1, 16'h0400, 32'h0);
      send_cmd(3'd1, 16'h0400, 32'h0);
      wait_valid();
      while (valid && hi < 40) begin
        hi++;
        tick();
      end
      chk("tmo_wait_cycles", hi, 15);
      capture(cw);
      chk("tmo_flag", cw[B_TMO], 1);
      expect_cmd(3'd1, 16'h0401, 32'h0);
      send_cmd(3'd1, 16'h0401, 32'h0);
      wait_valid();
      tick(14);
      respond(32'h0000_0BAD, 1'b0, 1'b0, 1'b0);
      capture(cw);
      chk("tmo_resp_wins_flag", cw[B_TMO], 0);
      chk("tmo_resp_wins_rdata", cw[HDW-1:0], 32'h0000_0BAD);
    end
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
